synaptic_event_fifo: RTL and testbench
======================================

Name: synaptic_event_fifo

Overview:
Buffers synaptic events between the spike fan-out logic and synaptic_processing_unit2. Each event is a 17-bit signed fixed-point weight plus a 1-bit source tag and a 1-bit destination tag. The output side uses first-word-fall-through: the head event is always visible, fifo_empty indicates validity, and the SPU consumes the head with a single-cycle req_deq pulse. The block also provides full, almost-full and sticky error flags for upstream backpressure and debug.

Parameters:
DEPTH, 8, number of event entries; must be a power of two, minimum 2.
ADDR_W, 3, log2(DEPTH); sets the pointer width.
WEIGHT_W, 17, weight width (1 sign bit + 16 fraction/integer bits, matching the SPU).
AF_LEVEL, 6, occupancy at or above which almost_full asserts.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
asyn_reset  in  1  asynchronous, active-low reset.
enq  in  1  write request; the event on the *_in ports is captured this edge.
weight_in  in  WEIGHT_W  synaptic weight to enqueue.
src_tag_in  in  1  source tag to enqueue.
dst_tag_in  in  1  destination tag to enqueue.
req_deq  in  1  dequeue request from the SPU; pops the head event.
weight_out  out  WEIGHT_W  head-entry weight; FWFT.
src_tag_out  out  1  head-entry source tag.
dst_tag_out  out  1  head-entry destination tag.
fifo_empty  out  1  high when no valid head entry exists.
full  out  1  high when count == DEPTH.
almost_full  out  1  high when count >= AF_LEVEL.
count  out  ADDR_W+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky; set by enq while full without a same-cycle deq.
underflow  out  1  sticky; set by req_deq while empty.

Behaviour:
- Reset (asyn_reset == 0, asynchronous):
  - rd_ptr = wr_ptr = 0 and count = 0.
  - fifo_empty = 1; full, almost_full, overflow and underflow = 0.
  - weight_out, src_tag_out and dst_tag_out = 0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Storage: DEPTH x (WEIGHT_W+2) register array. Write port at wr_ptr, combinational read at rd_ptr. Both pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- Outputs are registered-state derived:
  - fifo_empty = (count == 0), full = (count == DEPTH), almost_full = (count >= AF_LEVEL).
  - Data outputs present mem[rd_ptr] while non-empty and are forced to 0 while empty.
- Enqueue latency: data written at edge N appears on the outputs after edge N if the FIFO was empty, with fifo_empty deasserting the same cycle. Net latency is 1 cycle.
- Per-edge cases (e = effective enq, d = effective deq):
  - enq & !full -> write, wr_ptr++, count++.
  - enq & full & req_deq -> the deq frees a slot; both the write and the pop occur, count unchanged, no overflow.
  - enq & full & !req_deq -> event dropped, overflow <= 1, pointers and count unchanged.
  - req_deq & !empty -> rd_ptr++, count--.
  - req_deq & empty -> ignored; underflow <= 1. This holds even if enq is asserted the same cycle: the new entry is written but not popped, so count becomes 1.
  - enq & req_deq & 0 < count < DEPTH -> write and pop together, count unchanged.
- Arithmetic: count uses ADDR_W+1 bits and never exceeds DEPTH or goes below 0.
- Sticky flags clear only on reset.
- No combinational path from enq to fifo_empty or from req_deq to full.

Decomposition:
- Shared package snn_pkg holds:
  - constants WEIGHT_W = 17 and TAG_W = 1;
  - typedef syn_event_t {weight, src_tag, dst_tag};
  - localparam EVENT_W = WEIGHT_W + 2*TAG_W.
  - The SPU and the fan-out logic use the same package.
- One sub-module, event_regfile: 1-write/1-async-read register array parameterised by DEPTH and EVENT_W. Pointer, count and flag logic stay in synaptic_event_fifo.

Test Plan:
1. Reset and idle: hold asyn_reset=0 for 2 cycles, then release -> fifo_empty=1, count=0, all flags and data outputs 0. Assert asyn_reset=0 mid-clock after 3 enqueues -> count=0 and fifo_empty=1 before the next edge.
2. Single event: enq with weight_in=17'h00800, src_tag_in=0, dst_tag_in=1 -> next cycle fifo_empty=0, weight_out=17'h00800, dst_tag_out=1, count=1. Pulse req_deq one cycle -> fifo_empty=1, count=0, weight_out=0.
3. Fill and wrap: enqueue weights 1..8 -> full=1, almost_full=1 from count=6. A 9th enq with weight 9 -> overflow=1, count stays 8. Dequeue all -> weights out in order 1..8. Refill with 10..13 -> pointers wrapped, order preserved.
4. Simultaneous enq/deq at full: FIFO holds 1..8; enq weight 17'h10000 with req_deq -> count=8, overflow=0, head=2; the new entry emerges as the 8th item.
5. Underflow: req_deq while empty -> underflow=1, count=0. req_deq together with enq of 17'h00100 while empty -> count=1, head=17'h00100, underflow=1.
6. SPU back-to-back: enqueue 4 events and drive req_deq every other cycle as the SPU does -> each weight is presented exactly once, in order, and fifo_empty rises after the 4th pop.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared event format used by the spike fan-out logic, the event FIFO and the SPU.
package snn_pkg;

  localparam int WEIGHT_W = 17;
  localparam int TAG_W    = 1;
  localparam int EVENT_W  = WEIGHT_W + 2*TAG_W;

  typedef struct packed {
    logic [WEIGHT_W-1:0] weight;
    logic [TAG_W-1:0]    src_tag;
    logic [TAG_W-1:0]    dst_tag;
  } syn_event_t;

endpackage

// File: rtl/event_regfile.sv
// 1-write / 1-async-read register array holding packed synaptic events.
// Contents are intentionally not reset; validity is tracked by the owner.
module event_regfile #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int EVENT_W = snn_pkg::EVENT_W
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [EVENT_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [EVENT_W-1:0] rdata
);

  logic [EVENT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/synaptic_event_fifo.sv
// First-word-fall-through event FIFO between spike fan-out and the SPU, with
// occupancy, almost-full and sticky overflow/underflow flags.
module synaptic_event_fifo
  import snn_pkg::TAG_W;
#(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int WEIGHT_W = snn_pkg::WEIGHT_W,
  parameter int AF_LEVEL = 6
) (
  input  logic                clk,
  input  logic                asyn_reset,
  input  logic                enq,
  input  logic [WEIGHT_W-1:0] weight_in,
  input  logic [TAG_W-1:0]    src_tag_in,
  input  logic [TAG_W-1:0]    dst_tag_in,
  input  logic                req_deq,
  output logic [WEIGHT_W-1:0] weight_out,
  output logic [TAG_W-1:0]    src_tag_out,
  output logic [TAG_W-1:0]    dst_tag_out,
  output logic                fifo_empty,
  output logic                full,
  output logic                almost_full,
  output logic [ADDR_W:0]     count,
  output logic                overflow,
  output logic                underflow
);

  localparam int EV_W = WEIGHT_W + 2*TAG_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              is_empty, is_full, do_wr, do_rd;
  logic [EV_W-1:0]   head;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  // A pop at full frees the slot being written, so the write is accepted.
  assign do_wr    = enq & (~is_full | req_deq);
  assign do_rd    = req_deq & ~is_empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (enq & is_full & ~req_deq);
    udf_d    = udf_q | (req_deq & is_empty);
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  event_regfile #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .EVENT_W(EV_W)
  ) u_regfile (
    .clk  (clk),
    .we   (do_wr),
    .waddr(wr_ptr_q),
    .wdata({weight_in, src_tag_in, dst_tag_in}),
    .raddr(rd_ptr_q),
    .rdata(head)
  );

  assign {weight_out, src_tag_out, dst_tag_out} = is_empty ? '0 : head;
  assign fifo_empty  = is_empty;
  assign full        = is_full;
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_synaptic_event_fifo.sv
// Bench for synaptic_event_fifo: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_synaptic_event_fifo;
  import snn_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic        clk = 1'b0;
  logic        asyn_reset = 1'b0;
  logic        enq = 1'b0;
  logic [16:0] weight_in = '0;
  logic        src_tag_in = 1'b0;
  logic        dst_tag_in = 1'b0;
  logic        req_deq = 1'b0;
  logic [16:0] weight_out;
  logic        src_tag_out, dst_tag_out;
  logic        fifo_empty, full, almost_full;
  logic [3:0]  count;
  logic        overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  syn_event_t m_q[$];
  bit         m_ovf = 0;
  bit         m_udf = 0;

  synaptic_event_fifo dut (
    .clk(clk), .asyn_reset(asyn_reset), .enq(enq), .weight_in(weight_in),
    .src_tag_in(src_tag_in), .dst_tag_in(dst_tag_in), .req_deq(req_deq),
    .weight_out(weight_out), .src_tag_out(src_tag_out), .dst_tag_out(dst_tag_out),
    .fifo_empty(fifo_empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue semantics straight from the event rules.
  always @(negedge asyn_reset) begin
    m_q.delete();
    m_ovf = 0;
    m_udf = 0;
  end

  always @(posedge clk) begin
    if (asyn_reset) begin
      int n;
      syn_event_t ev;
      n = m_q.size();
      ev.weight = weight_in; ev.src_tag = src_tag_in; ev.dst_tag = dst_tag_in;
      if (req_deq && n == 0) m_udf = 1;
      if (enq && n == DEPTH && !req_deq) m_ovf = 1;
      if (req_deq && n > 0) void'(m_q.pop_front());
      if (enq && (n < DEPTH || req_deq)) m_q.push_back(ev);
    end
  end

  always @(negedge clk) begin
    if (asyn_reset) begin
      syn_event_t h;
      int n;
      n = m_q.size();
      h = (n > 0) ? m_q[0] : '0;
      check("m_weight", 32'(weight_out), 32'(h.weight));
      check("m_src", 32'(src_tag_out), 32'(h.src_tag));
      check("m_dst", 32'(dst_tag_out), 32'(h.dst_tag));
      check("m_count", 32'(count), 32'(n));
      check("m_empty", 32'(fifo_empty), 32'(n == 0));
      check("m_full", 32'(full), 32'(n == DEPTH));
      check("m_afull", 32'(almost_full), 32'(n >= AF));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
      check("m_udf", 32'(underflow), 32'(m_udf));
    end
  end

  task automatic step(input bit e, input logic [16:0] w, input bit s, input bit d, input bit q);
    enq = e; weight_in = w; src_tag_in = s; dst_tag_in = d; req_deq = q;
    @(posedge clk);
    #1;
    enq = 1'b0; req_deq = 1'b0;
  endtask

  task automatic do_reset();
    #2 asyn_reset = 1'b0;
    #1;
    check("rst_async_count", 32'(count), 32'd0);
    check("rst_async_empty", 32'(fifo_empty), 32'd1);
    @(posedge clk);
    #1 asyn_reset = 1'b1;
  endtask

  initial begin
    // 1. reset and idle
    repeat (2) @(posedge clk);
    #1 asyn_reset = 1'b1;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags", {28'd0, full, almost_full, overflow, underflow}, 32'd0);
    check("rst_data", {14'd0, weight_out, src_tag_out, dst_tag_out}, 32'd0);
    for (int i = 1; i <= 3; i++) step(1, 17'(i), 0, 0, 0);
    check("pre_rst_count", 32'(count), 32'd3);
    do_reset();

    // 2. single event
    step(1, 17'h00800, 0, 1, 0);
    check("single_empty", 32'(fifo_empty), 32'd0);
    check("single_weight", 32'(weight_out), 32'h00800);
    check("single_dst", 32'(dst_tag_out), 32'd1);
    check("single_count", 32'(count), 32'd1);
    step(0, 0, 0, 0, 1);
    check("single_pop_empty", 32'(fifo_empty), 32'd1);
    check("single_pop_weight", 32'(weight_out), 32'd0);

    // 3. fill, overflow, drain, wrap
    for (int i = 1; i <= 8; i++) begin
      step(1, 17'(i), 0, 0, 0);
      check("fill_afull", 32'(almost_full), 32'(i >= 6));
    end
    check("fill_full", 32'(full), 32'd1);
    step(1, 17'd9, 0, 0, 0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 32'(weight_out), 32'(i));
      step(0, 0, 0, 0, 1);
    end
    for (int i = 10; i <= 13; i++) step(1, 17'(i), 1, 0, 0);
    for (int i = 10; i <= 13; i++) begin
      check("wrap_order", 32'(weight_out), 32'(i));
      step(0, 0, 0, 0, 1);
    end
    do_reset();

    // 4. simultaneous enq/deq at full
    for (int i = 1; i <= 8; i++) step(1, 17'(i), 0, 0, 0);
    step(1, 17'h10000, 0, 0, 1);
    check("fullsim_count", 32'(count), 32'd8);
    check("fullsim_ovf", 32'(overflow), 32'd0);
    check("fullsim_head", 32'(weight_out), 32'd2);
    repeat (7) step(0, 0, 0, 0, 1);
    check("fullsim_8th", 32'(weight_out), 32'h10000);
    step(0, 0, 0, 0, 1);
    do_reset();

    // 5. underflow
    step(0, 0, 0, 0, 1);
    check("udf_flag", 32'(underflow), 32'd1);
    check("udf_count", 32'(count), 32'd0);
    step(1, 17'h00100, 0, 0, 1);
    check("udf_enq_count", 32'(count), 32'd1);
    check("udf_enq_head", 32'(weight_out), 32'h00100);
    check("udf_sticky", 32'(underflow), 32'd1);
    do_reset();

    // 6. SPU-style alternate-cycle dequeue
    for (int i = 0; i < 4; i++) step(1, 17'h01111 * 17'(i + 1), i[0], ~i[0], 0);
    for (int i = 0; i < 4; i++) begin
      check("spu_head", 32'(weight_out), 32'h01111 * 32'(i + 1));
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
    check("spu_empty", 32'(fifo_empty), 32'd1);

    // random traffic, occasional asynchronous reset
    for (int c = 0; c < 3000; c++) begin
      int phase;
      phase = c / 500;
      step($urandom_range(0, 99) < (phase[0] ? 70 : 35),
           17'($urandom_range(0, 17'h1FFFF)), 1'($urandom), 1'($urandom),
           $urandom_range(0, 99) < (phase[0] ? 30 : 60));
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
